uart_rx: RTL

- UART receiver: asynchronous serial line in, parallel byte out. Frame format is 8N1, LSB first: start bit 0, 8 data bits, stop bit 1.
- Counterpart of the team's UART transmitter. Same baud parameterisation.
- Sits between the external RX pin and the byte consumer.
- Single clock domain. Samples each bit at its centre using a clk-rate counter; no derived clocks.

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, centre-sampled with a clk-rate baud counter.
// Ports:
//   clk       - system clock
//   rstn      - asynchronous active-low reset
//   rx        - serial line (asynchronous to clk, idle high)
//   rx_data   - last correctly framed byte, held until the next good frame
//   rx_valid  - one-cycle pulse when rx_data is updated
//   rx_busy   - high whenever the receiver is not idle
//   frame_err - one-cycle pulse when the stop bit is sampled low
module uart_rx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BAUDRATE     = 9600,
    parameter int unsigned CLK_FREQ_MHZ = 125
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_busy,
    output logic                  frame_err
);

    localparam int unsigned BAUDRATE_COUNT = (CLK_FREQ_MHZ * 1_000_000) / BAUDRATE;
    localparam int unsigned HALF_COUNT     = BAUDRATE_COUNT / 2;
    localparam int unsigned CNT_WIDTH      = $clog2(BAUDRATE_COUNT) + 1;
    localparam int unsigned BIT_WIDTH      = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BIT_WIDTH-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    rx_busy_q, rx_busy_d;
    logic                    rx_meta_q, rx_s_q, rx_prev_q;

    logic                    baud_done_c;
    logic                    half_done_c;
    logic                    fall_c;

    // Two-flop synchronizer plus one delay stage for edge detection; all idle high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall_c      = rx_prev_q & ~rx_s_q;
    assign baud_done_c = (baud_cnt_q == CNT_WIDTH'(BAUDRATE_COUNT - 1));
    assign half_done_c = (baud_cnt_q == CNT_WIDTH'(HALF_COUNT - 1));

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (fall_c) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Re-check the line at the start-bit centre; high means it was a glitch.
                if (half_done_c) begin
                    baud_cnt_d = '0;
                    state_d    = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (baud_done_c) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d  = bit_cnt_q + BIT_WIDTH'(1);
                    if (bit_cnt_q == BIT_WIDTH'(DATA_WIDTH - 1)) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop-bit lets an immediately following start bit be caught.
                if (baud_done_c) begin
                    baud_cnt_d = '0;
                    state_d    = ST_IDLE;
                    if (rx_s_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;

endmodule
